// File: rtl/audio_addr_seq.sv
// Multi-channel sample-address sequencer: each channel walks start..end on tick, one-shot or looping.
// Optional AUDIO_SEQ_PINGPONG_EN: loop-mode channels bounce between start and end instead of jumping back.
module audio_addr_seq #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         tick,
    input  logic                         hold,
    input  logic [CHANNELS-1:0]          start,
    input  logic [CHANNELS-1:0]          stop,
    input  logic [CHANNELS-1:0]          loop,
    input  logic [CHANNELS*ADDR_W-1:0]   start_addr,
    input  logic [CHANNELS*ADDR_W-1:0]   end_addr,
    output logic [CHANNELS*ADDR_W-1:0]   addr,
    output logic [CHANNELS-1:0]          active,
    output logic [CHANNELS-1:0]          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        state_t              state_q;
        logic [ADDR_W-1:0]   addr_q;
        logic [ADDR_W-1:0]   st_q;
        logic [ADDR_W-1:0]   end_q;
        logic                loop_q;
        logic                done_q;
        logic                step_c;
`ifdef AUDIO_SEQ_PINGPONG_EN
        localparam logic DIR_UP = 1'b0;
        localparam logic DIR_DN = 1'b1;
        logic                dir_q;
`endif

        assign step_c = (state_q == RUN) && tick && !hold;

        // Start overrides stop and any final tick, so a restart never emits done.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                state_q <= IDLE;
                addr_q  <= '0;
                st_q    <= '0;
                end_q   <= '0;
                loop_q  <= 1'b0;
                done_q  <= 1'b0;
`ifdef AUDIO_SEQ_PINGPONG_EN
                dir_q   <= DIR_UP;
`endif
            end else begin
                done_q <= 1'b0;
                if (start[g]) begin
                    state_q <= RUN;
                    addr_q  <= start_addr[g*ADDR_W +: ADDR_W];
                    st_q    <= start_addr[g*ADDR_W +: ADDR_W];
                    end_q   <= end_addr[g*ADDR_W +: ADDR_W];
                    loop_q  <= loop[g];
`ifdef AUDIO_SEQ_PINGPONG_EN
                    dir_q   <= DIR_UP;
`endif
                end else if (state_q == RUN && stop[g]) begin
                    state_q <= IDLE;
                end else if (step_c) begin
`ifdef AUDIO_SEQ_PINGPONG_EN
                    if (loop_q) begin
                        if (dir_q == DIR_UP) begin
                            if (addr_q != end_q) begin
                                addr_q <= addr_q + ADDR_W'(1);
                            end else if (st_q != end_q) begin
                                dir_q  <= DIR_DN;
                                addr_q <= addr_q - ADDR_W'(1);
                            end
                        end else begin
                            if (addr_q != st_q) begin
                                addr_q <= addr_q - ADDR_W'(1);
                            end else begin
                                dir_q  <= DIR_UP;
                                addr_q <= addr_q + ADDR_W'(1);
                            end
                        end
                    end else
`endif
                    if (addr_q != end_q) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end else if (loop_q) begin
                        addr_q <= st_q;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
            end
        end

        assign addr[g*ADDR_W +: ADDR_W] = addr_q;
        assign active[g]                = (state_q == RUN);
        assign done[g]                  = done_q;
    end

endmodule
